instr_fetch_seq: RTL and testbench
==================================

# instr_fetch_seq

Fetch sequencer for the byte-wide, asynchronous-read instruction ROM. It owns the program counter and walks the ROM one byte per cycle over four cycles. It assembles each 32-bit instruction big-endian: the byte at PC becomes bits [31:24]. The finished instruction and its PC go to decode over a valid/ready handshake. It sits between the PC/branch logic and decode, and is the only master of the ROM address port.

## Interface
- ADDRESS_WIDTH, 32, PC and ROM byte-address width
- DATA_WIDTH, 8, ROM byte width
- INSTRUCTION_WIDTH, 32, assembled instruction width (4 × DATA_WIDTH)
- MEM_BYTES, 28, ROM depth in bytes; valid PCs are 0..MEM_BYTES-4
- RESET_PC, 0, PC after reset

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- mem_addr  out  ADDRESS_WIDTH  ROM byte address
- mem_rdata  in  DATA_WIDTH  ROM byte, combinational from mem_addr
- redirect_valid  in  1  load new PC (branch/jump)
- redirect_pc  in  ADDRESS_WIDTH  target PC; bits [1:0] are ignored and forced to 0
- instr_valid  out  1  instr/instr_pc hold a complete instruction
- instr_ready  in  1  decode accepts instruction
- instr  out  INSTRUCTION_WIDTH  assembled instruction
- instr_pc  out  ADDRESS_WIDTH  PC of instr
- fault  out  1  PC is outside the ROM; fetch is stopped

## Operation
- State: FETCH, HOLD, FAULT. Registers: pc, 2-bit byte counter cnt, instr shift/assembly register.
- Reset (async, while rst_n=0): state=FETCH, pc=RESET_PC, cnt=0, instr=0, instr_pc=RESET_PC, instr_valid=0, fault=0. mem_addr therefore equals RESET_PC.
- mem_addr is always pc + cnt, modulo 2^ADDRESS_WIDTH. In HOLD and FAULT, cnt=0.
- FETCH, cnt=0, pc > MEM_BYTES-4: go to FAULT and capture nothing.
- FETCH, otherwise:
  - Capture mem_rdata into byte lane cnt (lane 0 = [31:24], lane 3 = [7:0]), then cnt++.
  - At cnt=3: go to HOLD with instr_valid=1 and instr_pc=pc, and set cnt to 0.
- HOLD:
  - instr_valid=1. instr and instr_pc are stable while instr_ready=0.
  - On instr_valid && instr_ready: pc <= pc+4 (wraps modulo 2^ADDRESS_WIDTH), then go to FETCH.
- FAULT: fault=1 and instr_valid=0. State is held until a redirect.
- Redirect, in any state, has priority over all of the above:
  - pc <= {redirect_pc[ADDRESS_WIDTH-1:2],2'b00}, cnt <= 0, instr_valid <= 0, fault <= 0, then go to FETCH.
  - Any partially assembled bytes are discarded.
- Redirect in the same cycle as a HOLD handshake: the transfer counts as consumed by decode. The next PC is the redirect target, not pc+4.
- instr_pc and instr outside HOLD: keep their last values, with no meaning while instr_valid=0.

## Timing
- One ROM byte per cycle. mem_rdata is sampled on the same rising edge that ends the cycle mem_addr was driven.
- Fetch latency: instr_valid rises on the 4th rising edge after the FETCH cycle in which cnt=0. With zero backpressure, the first instruction is valid in cycle 5 after reset release.
- Throughput: one instruction per 5 cycles with instr_ready held high (4 FETCH + 1 HOLD).
- Redirect: takes effect at the next edge. The target's first byte is addressed in the following cycle, and instr_valid for the target follows 4 edges later.
- Fault: fault rises one edge after entering FETCH with an out-of-range pc.
- Reset asserted mid-fetch: all outputs take reset values immediately (async), with no partial instruction emitted.

## Test plan
- Reset/basic: ROM bytes 0..7 = 00 50 02 93 00 10 03 13, instr_ready=1.
  - mem_addr steps 0,1,2,3.
  - instr_valid=1 in cycle 5 with instr=0x00500293, instr_pc=0.
  - Next instr=0x00100313 with instr_pc=4, 5 cycles later.
- Backpressure: hold instr_ready=0 for 10 cycles in HOLD.
  - instr_valid, instr=0x00500293 and mem_addr=0 stay stable.
  - Raising ready gives one transfer, then mem_addr=4.
- Redirect mid-fetch: assert redirect_pc=0x0000000B at cnt=2.
  - Partial word dropped and instr_valid stays 0.
  - mem_addr goes 8,9,10,11, then instr_pc=8.
- Redirect during handshake: redirect_pc=0x10 together with valid&&ready at pc=0.
  - Exactly one transfer occurs.
  - The next instr_pc is 0x10, not 4.
- Fault: run to pc=24.
  - pc=24 fetches normally.
  - After the handshake, pc=28 gives fault=1 one edge later, instr_valid=0, and mem_addr frozen at 28.
  - Redirect to 0 clears fault and refetches 0x00500293.
- Async reset: drop rst_n mid-HOLD, asynchronously to clk.
  - instr_valid=0, fault=0 and mem_addr=RESET_PC with no clock edge.
  - After release, normal fetch from RESET_PC.

Source files
------------

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: walks a byte-wide async-read ROM four bytes per
// instruction, assembles big-endian words and hands them to decode over valid/ready.
module instr_fetch_seq #(
  parameter int unsigned ADDRESS_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned INSTRUCTION_WIDTH = 32,
  parameter int unsigned MEM_BYTES         = 28,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = {ADDRESS_WIDTH{1'b0}}
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic [ADDRESS_WIDTH-1:0]     mem_addr,
  input  logic [DATA_WIDTH-1:0]        mem_rdata,
  input  logic                         redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0]     redirect_pc,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic [INSTRUCTION_WIDTH-1:0] instr,
  output logic [ADDRESS_WIDTH-1:0]     instr_pc,
  output logic                         fault
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_PC = ADDRESS_WIDTH'(MEM_BYTES - 4);

  state_t                         state_r, state_nxt_s;
  logic [ADDRESS_WIDTH-1:0]       pc_r, pc_nxt_s;
  logic [1:0]                     cnt_r, cnt_nxt_s;
  logic [INSTRUCTION_WIDTH-1:0]   instr_r, instr_nxt_s;
  logic [ADDRESS_WIDTH-1:0]       instr_pc_r, instr_pc_nxt_s;
  logic                           instr_valid_r, instr_valid_nxt_s;
  logic                           fault_r, fault_nxt_s;
  logic                           out_of_range_s;
  logic [ADDRESS_WIDTH-1:0]       redirect_target_s;

  assign out_of_range_s    = (pc_r > LAST_PC);
  assign redirect_target_s = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
  assign mem_addr          = pc_r + ADDRESS_WIDTH'(cnt_r);

  assign instr       = instr_r;
  assign instr_pc    = instr_pc_r;
  assign instr_valid = instr_valid_r;
  assign fault       = fault_r;

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_FETCH;
      pc_r          <= RESET_PC;
      cnt_r         <= 2'd0;
      instr_r       <= {INSTRUCTION_WIDTH{1'b0}};
      instr_pc_r    <= RESET_PC;
      instr_valid_r <= 1'b0;
      fault_r       <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      pc_r          <= pc_nxt_s;
      cnt_r         <= cnt_nxt_s;
      instr_r       <= instr_nxt_s;
      instr_pc_r    <= instr_pc_nxt_s;
      instr_valid_r <= instr_valid_nxt_s;
      fault_r       <= fault_nxt_s;
    end
  end

  // Next-state selection; a redirect overrides every state.
  always_comb begin
    state_nxt_s = state_r;
    if (redirect_valid) begin
      state_nxt_s = ST_FETCH;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if ((cnt_r == 2'd0) && out_of_range_s) begin
            state_nxt_s = ST_FAULT;
          end else if (cnt_r == 2'd3) begin
            state_nxt_s = ST_HOLD;
          end else begin
            state_nxt_s = ST_FETCH;
          end
        end
        ST_HOLD: begin
          if (instr_ready) begin
            state_nxt_s = ST_FETCH;
          end else begin
            state_nxt_s = ST_HOLD;
          end
        end
        ST_FAULT: state_nxt_s = ST_FAULT;
        default:  state_nxt_s = ST_FAULT;
      endcase
    end
  end

  // Datapath and output next values for each state.
  always_comb begin
    pc_nxt_s          = pc_r;
    cnt_nxt_s         = cnt_r;
    instr_nxt_s       = instr_r;
    instr_pc_nxt_s    = instr_pc_r;
    instr_valid_nxt_s = instr_valid_r;
    fault_nxt_s       = fault_r;
    if (redirect_valid) begin
      // A handshake in this same cycle still completes; only the next PC changes.
      pc_nxt_s          = redirect_target_s;
      cnt_nxt_s         = 2'd0;
      instr_valid_nxt_s = 1'b0;
      fault_nxt_s       = 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if ((cnt_r == 2'd0) && out_of_range_s) begin
            fault_nxt_s       = 1'b1;
            instr_valid_nxt_s = 1'b0;
          end else begin
            case (cnt_r)
              2'd0:    instr_nxt_s[INSTRUCTION_WIDTH-1 -: DATA_WIDTH]              = mem_rdata;
              2'd1:    instr_nxt_s[INSTRUCTION_WIDTH-1-DATA_WIDTH -: DATA_WIDTH]   = mem_rdata;
              2'd2:    instr_nxt_s[INSTRUCTION_WIDTH-1-2*DATA_WIDTH -: DATA_WIDTH] = mem_rdata;
              2'd3:    instr_nxt_s[DATA_WIDTH-1:0]                                 = mem_rdata;
              default: instr_nxt_s = instr_r;
            endcase
            if (cnt_r == 2'd3) begin
              cnt_nxt_s         = 2'd0;
              instr_valid_nxt_s = 1'b1;
              instr_pc_nxt_s    = pc_r;
            end else begin
              cnt_nxt_s = cnt_r + 2'd1;
            end
          end
        end
        ST_HOLD: begin
          if (instr_ready) begin
            pc_nxt_s          = pc_r + ADDRESS_WIDTH'(4);
            instr_valid_nxt_s = 1'b0;
          end else begin
            instr_valid_nxt_s = 1'b1;
          end
        end
        ST_FAULT: begin
          fault_nxt_s       = 1'b1;
          instr_valid_nxt_s = 1'b0;
          cnt_nxt_s         = 2'd0;
        end
        default: begin
          fault_nxt_s       = 1'b1;
          instr_valid_nxt_s = 1'b0;
          cnt_nxt_s         = 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq: ROM model, age-based reference model
// compared every cycle, plus hand-computed literal checkpoints.
module tb_instr_fetch_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fault;

  int n_checks = 0;
  int n_fail   = 0;
  int xfers    = 0;

  logic [7:0] rom_mem [0:31];

  instr_fetch_seq dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr < 32'd28) ? rom_mem[mem_addr[4:0]] : 8'h00;

  function automatic logic [7:0] rom_at(input logic [31:0] a);
    return (a < 32'd28) ? rom_mem[a[4:0]] : 8'h00;
  endfunction

  // Reference model: instruction at pc is "age" cycles into its fetch; age 4 = offered.
  logic [31:0] m_pc;
  int          m_age;
  bit          m_fault;
  bit          m_ok = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc    <= 32'd0;
      m_age   <= 0;
      m_fault <= 1'b0;
      m_ok    <= 1'b1;
    end else if (redirect_valid) begin
      m_pc    <= redirect_pc & 32'hFFFF_FFFC;
      m_age   <= 0;
      m_fault <= 1'b0;
    end else if (!m_fault) begin
      if (m_age == 0 && m_pc > 32'd24) begin
        m_fault <= 1'b1;
      end else if (m_age < 4) begin
        m_age <= m_age + 1;
      end else if (instr_ready) begin
        m_pc  <= m_pc + 32'd4;
        m_age <= 0;
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && instr_valid && instr_ready) xfers <= xfers + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_ok) begin
      logic        e_valid;
      logic [31:0] e_addr;
      e_valid = !m_fault && (m_age == 4);
      e_addr  = (m_fault || m_age >= 4) ? m_pc : m_pc + 32'(m_age);
      check("model_mem_addr", mem_addr, e_addr);
      check("model_valid", {31'd0, instr_valid}, {31'd0, e_valid});
      check("model_fault", {31'd0, fault}, {31'd0, m_fault});
      if (e_valid) begin
        check("model_instr", instr,
              {rom_at(m_pc), rom_at(m_pc + 32'd1), rom_at(m_pc + 32'd2), rom_at(m_pc + 32'd3)});
        check("model_instr_pc", instr_pc, m_pc);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int x0;
    rom_mem[0] = 8'h00; rom_mem[1] = 8'h50; rom_mem[2] = 8'h02; rom_mem[3] = 8'h93;
    rom_mem[4] = 8'h00; rom_mem[5] = 8'h10; rom_mem[6] = 8'h03; rom_mem[7] = 8'h13;
    for (int i = 8; i < 32; i++) rom_mem[i] = 8'(i * 17);

    rst_n = 1'b0; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    rst_n = 1'b1;

    // Basic fetch
    check("addr0", mem_addr, 32'd0);
    cyc(1); check("addr1", mem_addr, 32'd1);
    cyc(1); check("addr2", mem_addr, 32'd2);
    cyc(1); check("addr3", mem_addr, 32'd3);
    check("no_valid_early", {31'd0, instr_valid}, 32'd0);
    cyc(1);
    check("i0_valid", {31'd0, instr_valid}, 32'd1);
    check("i0_instr", instr, 32'h0050_0293);
    check("i0_pc", instr_pc, 32'd0);
    cyc(5);
    check("i1_valid", {31'd0, instr_valid}, 32'd1);
    check("i1_instr", instr, 32'h0010_0313);
    check("i1_pc", instr_pc, 32'd4);

    // Backpressure on the first word
    instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'd0;
    cyc(1);
    redirect_valid = 1'b0;
    check("bp_redir_addr", mem_addr, 32'd0);
    cyc(4);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", {31'd0, instr_valid}, 32'd1);
      check("bp_instr", instr, 32'h0050_0293);
      check("bp_addr", mem_addr, 32'd0);
      cyc(1);
    end
    x0 = xfers;
    instr_ready = 1'b1;
    cyc(1);
    check("bp_one_xfer", 32'(xfers - x0), 32'd1);
    check("bp_addr_next", mem_addr, 32'd4);
    check("bp_valid_drop", {31'd0, instr_valid}, 32'd0);

    // Redirect mid-fetch at cnt=2
    cyc(2);
    check("mid_addr6", mem_addr, 32'd6);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_000B;
    cyc(1);
    redirect_valid = 1'b0;
    check("mid_addr8", mem_addr, 32'd8);
    cyc(1); check("mid_addr9", mem_addr, 32'd9);
    cyc(1); check("mid_addr10", mem_addr, 32'd10);
    cyc(1); check("mid_addr11", mem_addr, 32'd11);
    check("mid_no_valid", {31'd0, instr_valid}, 32'd0);
    cyc(1);
    check("mid_pc", instr_pc, 32'd8);
    check("mid_instr", instr, 32'h8899_AABB);

    // Redirect during handshake
    redirect_valid = 1'b1; redirect_pc = 32'd0;
    cyc(1);
    redirect_valid = 1'b0;
    cyc(4);
    check("hs_pc0", instr_pc, 32'd0);
    x0 = xfers;
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    cyc(1);
    redirect_valid = 1'b0;
    check("hs_one_xfer", 32'(xfers - x0), 32'd1);
    check("hs_addr", mem_addr, 32'h10);
    cyc(4);
    check("hs_pc", instr_pc, 32'h10);
    check("hs_instr", instr, 32'h1021_3243);

    // Run to the end of the ROM and into fault
    cyc(5);
    check("f_pc20", instr_pc, 32'd20);
    cyc(1);
    check("f_addr24", mem_addr, 32'd24);
    cyc(4);
    check("f_pc24", instr_pc, 32'd24);
    check("f_instr24", instr, 32'h98A9_BACB);
    cyc(1);
    check("f_addr28", mem_addr, 32'd28);
    check("f_not_yet", {31'd0, fault}, 32'd0);
    cyc(1);
    check("f_fault", {31'd0, fault}, 32'd1);
    check("f_valid", {31'd0, instr_valid}, 32'd0);
    cyc(3);
    check("f_frozen", mem_addr, 32'd28);
    check("f_held", {31'd0, fault}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'd0;
    cyc(1);
    redirect_valid = 1'b0;
    check("f_cleared", {31'd0, fault}, 32'd0);
    check("f_addr0", mem_addr, 32'd0);
    cyc(4);
    check("f_refetch", instr, 32'h0050_0293);

    // Asynchronous reset mid-HOLD
    cyc(5);
    instr_ready = 1'b0;
    cyc(2);
    check("ar_pre_addr", mem_addr, 32'd4);
    check("ar_pre_valid", {31'd0, instr_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("ar_valid", {31'd0, instr_valid}, 32'd0);
    check("ar_fault", {31'd0, fault}, 32'd0);
    check("ar_addr", mem_addr, 32'd0);
    cyc(1);
    rst_n = 1'b1; instr_ready = 1'b1;
    check("ar_rel_addr", mem_addr, 32'd0);
    cyc(4);
    check("ar_instr", instr, 32'h0050_0293);
    check("ar_pc", instr_pc, 32'd0);
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
